b12_key_conditioner: RTL and testbench

//  Front end for the b12 memory game. Cleans up the raw keypad and start button, then drives b12's k[3:0] and start inputs.
//  - Each line is synchronised and debounced.
//  - k is one-hot; chords (several keys at once) are rejected.
//  - start becomes a single-cycle pulse, so a held button cannot keep restarting the game.

---
 rtl/b12_pkg.sv | 30 +++
 rtl/b12_debounce_cell.sv | 47 ++++
 rtl/b12_key_conditioner.sv | 119 +++++++++++
 tb/tb_b12_key_conditioner.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/b12_pkg.sv
// Shared definitions for the b12 key conditioner: key count, active level,
// arbiter state encoding and small one-hot helpers.
package b12_pkg;

    localparam int   NUM_KEY = 4;
    localparam logic KEY_ON  = 1'b1;
    localparam int   IDX_W   = (NUM_KEY > 1) ? $clog2(NUM_KEY) : 1;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_PRESSED = 2'd1,
        ARB_CHORD   = 2'd2
    } arb_state_t;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [NUM_KEY-1:0] v);
        return (v != '0) && ((v & (v - NUM_KEY'(1))) == '0);
    endfunction

    // Index of the (single) set bit; only meaningful when is_onehot(v).
    function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_KEY-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_KEY; i++) begin
            if (v[i] == KEY_ON) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/b12_debounce_cell.sv
// One input line: SYNC_STAGES-deep synchroniser followed by a saturating
// debounce counter. The accepted level o_st only flips after the synced
// input has disagreed with it for DEB_CYCLES consecutive cycles.
module b12_debounce_cell #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16,
    parameter int CNT_W       = 5
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_st
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_st;
    logic                   w_in;

    assign w_in = r_sync[SYNC_STAGES-1];
    assign o_st = r_st;

    // Metastability chain: raw contact shifts in at bit 0.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_sync <= '0;
        else         r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end

    // Count cycles of disagreement; any agreeing cycle restarts the count,
    // and the counter is cleared on toggle so it can never wrap.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
            r_st  <= 1'b0;
        end else if (w_in == r_st) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_st  <= ~r_st;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/b12_key_conditioner.sv
// Front end for the b12 memory game. Debounces NUM_KEY key lines plus the
// start button, turns start into a single-cycle pulse and arbitrates the
// keys into a strictly one-hot (or zero) k vector, rejecting chords.
module b12_key_conditioner
    import b12_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16,
    parameter int CNT_W       = 5
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NUM_KEY-1:0] i_raw_key,
    input  logic               i_raw_start,
    output logic [NUM_KEY-1:0] o_k,
    output logic               o_start,
    output logic               o_chord_err
);

    // Line NUM_KEY is the start button; lines below it are the keys.
    logic [NUM_KEY:0]   w_raw;
    logic [NUM_KEY:0]   w_deb_all;
    logic [NUM_KEY-1:0] w_key_deb;
    logic               w_start_deb;
    logic               w_start_rise;

    logic               r_start_d;
    logic               r_start;
    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [NUM_KEY-1:0] r_k;
    logic               r_chord_err;

    assign w_raw       = {i_raw_start, i_raw_key};
    assign w_key_deb   = w_deb_all[NUM_KEY-1:0];
    assign w_start_deb = w_deb_all[NUM_KEY];

    genvar g;
    generate
        for (g = 0; g <= NUM_KEY; g++) begin : g_line
            b12_debounce_cell #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEB_CYCLES  (DEB_CYCLES),
                .CNT_W       (CNT_W)
            ) u_cell (
                .i_clock (i_clock),
                .i_reset (i_reset),
                .i_raw   (w_raw[g]),
                .o_st    (w_deb_all[g])
            );
        end
    endgenerate

    assign w_start_rise = w_start_deb & ~r_start_d;

    // Start edge detector: one pulse per accepted press, none while held.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_start_d <= 1'b0;
            r_start   <= 1'b0;
        end else begin
            r_start_d <= w_start_deb;
            r_start   <= w_start_rise;
        end
    end

    // Key arbiter. A start pulse overrides everything and parks the FSM in
    // CHORD so keys held across a restart are never reported to the new game.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ARB_IDLE;
            r_idx       <= '0;
            r_k         <= '0;
            r_chord_err <= 1'b0;
        end else begin
            r_chord_err <= 1'b0;
            if (w_start_rise) begin
                r_k     <= '0;
                r_state <= ARB_CHORD;
            end else begin
                case (r_state)
                    ARB_IDLE: begin
                        if (w_key_deb == '0) begin
                            r_k <= '0;
                        end else if (is_onehot(w_key_deb)) begin
                            r_idx   <= onehot_idx(w_key_deb);
                            r_k     <= w_key_deb;
                            r_state <= ARB_PRESSED;
                        end else begin
                            r_k         <= '0;
                            r_chord_err <= 1'b1;
                            r_state     <= ARB_CHORD;
                        end
                    end
                    ARB_PRESSED: begin
                        // Other keys are ignored while the latched one is held.
                        if (w_key_deb[r_idx] != KEY_ON) begin
                            r_k     <= '0;
                            r_state <= (w_key_deb == '0) ? ARB_IDLE : ARB_CHORD;
                        end
                    end
                    ARB_CHORD: begin
                        r_k <= '0;
                        if (w_key_deb == '0) r_state <= ARB_IDLE;
                    end
                    default: begin
                        r_k     <= '0;
                        r_state <= ARB_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_k         = r_k;
    assign o_start     = r_start;
    assign o_chord_err = r_chord_err;

endmodule

// File: tb/tb_b12_key_conditioner.sv
// Bench for b12_key_conditioner with SYNC_STAGES=2, DEB_CYCLES=4.
// Expected output events (k change, start pulse, chord_err pulse) are queued
// with their cycle stamp as stimulus is driven; a negedge monitor pops and
// compares every event the DUT produces.
module tb_b12_key_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LAT  = SYNC + DEB + 1;

    typedef struct {
        int         cyc;
        logic [3:0] k;
        logic       s;
        logic       ce;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] raw_key = 4'b0000;
    logic       raw_start = 1'b0;
    logic [3:0] o_k;
    logic       o_start;
    logic       o_chord_err;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   sb_en = 1'b1;
    bit   inv_en = 1'b0;
    ev_t  sb_q[$];
    logic [3:0] prev_k = 4'b0000;
    logic       prev_start = 1'b0;

    b12_key_conditioner #(
        .SYNC_STAGES (SYNC),
        .DEB_CYCLES  (DEB),
        .CNT_W       (3)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_raw_key   (raw_key),
        .i_raw_start (raw_start),
        .o_k         (o_k),
        .o_start     (o_start),
        .o_chord_err (o_chord_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard and invariant monitor.
    always @(negedge clk) begin
        ev_t e;
        if (sb_en && ((o_k !== prev_k) || o_start || o_chord_err)) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event cyc=%0d k=%b start=%b chord_err=%b, required no event",
                         cyc, o_k, o_start, o_chord_err);
            end else begin
                e = sb_q.pop_front();
                if (e.cyc != cyc || e.k !== o_k || e.s !== o_start || e.ce !== o_chord_err) begin
                    n_err++;
                    $display("FAIL sb_event got cyc=%0d k=%b start=%b ce=%b, required cyc=%0d k=%b start=%b ce=%b",
                             cyc, o_k, o_start, o_chord_err, e.cyc, e.k, e.s, e.ce);
                end
            end
        end
        if (inv_en) begin
            n_cmp++;
            if ($countones(o_k) > 1) begin
                n_err++;
                $display("FAIL inv_onehot cyc=%0d k=%b, required at most one bit", cyc, o_k);
            end
            n_cmp++;
            if (o_start && prev_start) begin
                n_err++;
                $display("FAIL inv_start_pulse cyc=%0d start high two cycles, required single cycle", cyc);
            end
        end
        prev_k     = o_k;
        prev_start = o_start;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cyc=%0d, required completion", cyc);
        $fatal(1, "timeout");
    end

    function automatic void push_ev(int c, logic [3:0] k, logic s, logic ce);
        ev_t e;
        e.cyc = c; e.k = k; e.s = s; e.ce = ce;
        sb_q.push_back(e);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 60;
        while (sb_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain pending=%0d events, required 0", name, sb_q.size());
            sb_q.delete();
        end
        tick(4);
    endtask

    task automatic test_reset;
        n_cmp++;
        if (o_k !== 4'b0000 || o_start !== 1'b0 || o_chord_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state k=%b start=%b ce=%b, required 0/0/0", o_k, o_start, o_chord_err);
        end
        tick(2);
        rst = 1'b0;
        tick(2);
        raw_key = 4'b0010;
        push_ev(cyc + LAT, 4'b0010, 1'b0, 1'b0);
        tick(10);
        // Assert reset mid-cycle while the key is held.
        @(posedge clk);
        #2;
        push_ev(cyc, 4'b0000, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (o_k !== 4'b0000 || o_start !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async k=%b start=%b, required 0/0", o_k, o_start);
        end
        @(negedge clk);
        rst = 1'b0;
        push_ev(cyc + LAT, 4'b0010, 1'b0, 1'b0);
        tick(12);
        raw_key = 4'b0000;
        push_ev(cyc + LAT, 4'b0000, 1'b0, 1'b0);
        drain("reset");
    endtask

    task automatic test_bounce;
        for (int i = 0; i < 4; i++) begin
            raw_key[0] = (i % 2 == 0);
            tick(3);
        end
        raw_key[0] = 1'b1;
        push_ev(cyc + LAT, 4'b0001, 1'b0, 1'b0);
        tick(12);
        raw_key[0] = 1'b0;
        push_ev(cyc + LAT, 4'b0000, 1'b0, 1'b0);
        drain("bounce");
    endtask

    task automatic test_chord;
        raw_key = 4'b0101;
        push_ev(cyc + LAT, 4'b0000, 1'b0, 1'b1);
        tick(12);
        raw_key = 4'b0000;
        tick(12);
        raw_key = 4'b0010;
        push_ev(cyc + LAT, 4'b0010, 1'b0, 1'b0);
        tick(12);
        raw_key = 4'b0000;
        push_ev(cyc + LAT, 4'b0000, 1'b0, 1'b0);
        drain("chord");
    endtask

    task automatic test_extra_key;
        raw_key = 4'b1000;
        push_ev(cyc + LAT, 4'b1000, 1'b0, 1'b0);
        tick(12);
        raw_key = 4'b1010;
        tick(12);
        raw_key = 4'b0010;
        push_ev(cyc + LAT, 4'b0000, 1'b0, 1'b0);
        tick(12);
        raw_key = 4'b0000;
        tick(12);
        raw_key = 4'b0010;
        push_ev(cyc + LAT, 4'b0010, 1'b0, 1'b0);
        tick(12);
        raw_key = 4'b0000;
        push_ev(cyc + LAT, 4'b0000, 1'b0, 1'b0);
        drain("extra_key");
    endtask

    task automatic test_start;
        // Held button: exactly one pulse.
        raw_start = 1'b1;
        push_ev(cyc + LAT, 4'b0000, 1'b1, 1'b0);
        tick(50);
        raw_start = 1'b0;
        tick(12);
        // Start while key 2 is held: k drops with the pulse, stays 0 until release.
        raw_key = 4'b0100;
        push_ev(cyc + LAT, 4'b0100, 1'b0, 1'b0);
        tick(12);
        raw_start = 1'b1;
        push_ev(cyc + LAT, 4'b0000, 1'b1, 1'b0);
        tick(50);
        raw_start = 1'b0;
        tick(12);
        raw_key = 4'b0000;
        tick(12);
        raw_key = 4'b0100;
        push_ev(cyc + LAT, 4'b0100, 1'b0, 1'b0);
        tick(12);
        raw_key = 4'b0000;
        push_ev(cyc + LAT, 4'b0000, 1'b0, 1'b0);
        drain("start_key");
        // Start and a single key accepted in the same cycle: start wins.
        raw_start = 1'b1;
        raw_key   = 4'b0001;
        push_ev(cyc + LAT, 4'b0000, 1'b1, 1'b0);
        tick(12);
        raw_start = 1'b0;
        raw_key   = 4'b0000;
        tick(12);
        raw_key = 4'b0001;
        push_ev(cyc + LAT, 4'b0001, 1'b0, 1'b0);
        tick(12);
        raw_key = 4'b0000;
        push_ev(cyc + LAT, 4'b0000, 1'b0, 1'b0);
        drain("start_simul");
    endtask

    task automatic test_soak;
        sb_en  = 1'b0;
        inv_en = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0)  raw_key = 4'($urandom);
            if ($urandom_range(15) == 0) raw_start = ~raw_start;
        end
        raw_key   = 4'b0000;
        raw_start = 1'b0;
        tick(20);
        inv_en = 1'b0;
        sb_en  = 1'b1;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_chord();
        test_extra_key();
        test_start();
        test_soak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
